lsu_multiciclo: RTL and testbench

- Parametrised multicycle load/store unit between the datapath's ALU address and the data memory.
- Supersedes the combinational load/store blocks and the direct data-memory hookup.
- Handles byte/half/word/double accesses with sign or zero extension.
- Performs read-modify-write for sub-word stores against a full-width memory, flags misaligned accesses, and tolerates a configurable memory read latency through a valid/ready request and single-cycle response handshake.

---
 rtl/lsu_multiciclo.sv | 93 +++++++++
 tb/tb_lsu_multiciclo.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lsu_multiciclo.sv
// lsu_multiciclo: multicycle load/store unit with sub-word read-modify-write,
// sign/zero extension, misalignment detection and configurable memory read latency.
module lsu_multiciclo #(
   parameter int XLEN    = 64,
   parameter int ADDR_W  = 64,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_error,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic              mem_wr,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int CNT_W = $clog2(MEM_LAT + 1) + 1;
   localparam logic [1:0] FULL = (XLEN == 64) ? 2'd3 : 2'd2;
   localparam logic [XLEN-1:0] ONE = 1;
   typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;
   state_t state, state_n;
   logic we_q, uns_q, accept, bad, done, sign;
   logic [1:0] size_q;
   logic [OFF_W-1:0] off_q;
   logic [OFF_W+2:0] bit_off;
   logic [CNT_W-1:0] cnt;
   logic [6:0] nbits;
   logic [XLEN-1:0] wdata_q, mask, shifted, load_val, merged;
   assign req_ready = state == IDLE;
   assign accept    = req_valid && req_ready;
   assign bad       = (req_size == 2'd3 && XLEN == 32) || |(req_addr[2:0] & ((3'd1 << req_size) - 3'd1));
   assign done      = cnt == CNT_W'(MEM_LAT);
   // mask covers the access width; at full width the shift overflows to 0 and the mask becomes all ones
   assign nbits     = 7'd8 << size_q;
   assign mask      = (ONE << nbits) - ONE;
   assign bit_off   = {off_q, 3'b000};
   assign shifted   = mem_rdata >> bit_off;
   assign sign      = |(shifted & mask & ~(mask >> 1));
   assign load_val  = (shifted & mask) | ((!uns_q && sign) ? ~mask : '0);
   assign merged    = (mem_rdata & ~(mask << bit_off)) | ((wdata_q & mask) << bit_off);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = bad ? ERR : (req_we && req_size == FULL) ? WR : RD;
         RD:      if (done) state_n = we_q ? WR : RESP;
         WR:      state_n = RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         resp_valid <= 1'b0;
         resp_error <= 1'b0;
         resp_rdata <= '0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cnt        <= '0;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
      end else begin
         resp_valid <= state_n == RESP || state_n == ERR;
         resp_error <= state_n == ERR;
         resp_rdata <= (state == RD && done && !we_q) ? load_val : '0;
         mem_wr     <= state_n == WR;
         cnt        <= (state == RD) ? cnt + 1'b1 : '0;
         if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            off_q   <= req_addr[OFF_W-1:0];
            wdata_q <= req_wdata;
            if (!bad) mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (!bad && req_we && req_size == FULL) mem_wdata <= req_wdata;
         end
         if (state == RD && done && we_q) mem_wdata <= merged;
      end
endmodule

// File: tb/tb_lsu_multiciclo.sv
// tb_lsu_multiciclo: directed vectors with a response scoreboard against a small
// registered-read memory model (XLEN=64, MEM_LAT=1).
module tb_lsu_multiciclo;
   logic clk = 0, rst = 1;
   logic req_valid = 0, req_we = 0, req_unsigned = 0;
   logic [1:0] req_size = 0;
   logic [63:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
   logic req_ready, resp_valid, resp_error, mem_wr;
   logic [63:0] resp_rdata, mem_addr, mem_wdata;
   logic [63:0] mem [0:63];
   int cyc = 0, acc = 0, wr_cnt = 0, wr_lat = 0, nchk = 0, nerr = 0;
   logic [63:0] last_wa = 0, last_wd = 0;
   typedef struct {logic [63:0] rdata; logic err; int lat; int acc;} exp_t;
   exp_t q[$];

   lsu_multiciclo #(.XLEN(64), .ADDR_W(64), .MEM_LAT(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr[8:3]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[8:3]];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mem_wr) begin
         wr_cnt++;
         wr_lat = cyc - acc + 1;
         last_wa = mem_addr;
         last_wd = mem_wdata;
      end
      if (resp_valid) begin
         if (q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
         else begin
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_error", {63'd0, resp_error}, {63'd0, e.err});
            chk("resp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [63:0] a, input logic [63:0] wd);
      @(negedge clk);
      req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1;
      @(posedge clk);
      #1;
      req_valid = 0;
      acc = cyc;
   endtask

   task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee, input int lat,
                       input int wrs, input int wrl);
      int w0, busy;
      exp_t e;
      w0 = wr_cnt;
      issue(we, sz, uns, a, wd);
      e.rdata = er; e.err = ee; e.lat = lat; e.acc = acc;
      q.push_back(e);
      busy = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) break;
         busy++;
      end
      chk("ready_busy", 64'(busy), 64'(lat));
      chk("wr_pulses", 64'(wr_cnt - w0), 64'(wrs));
      if (wrs != 0) chk("wr_latency", 64'(wr_lat), 64'(wrl));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 64'h1111_0000_0000_0000 | 64'(i);
      mem[32] = 64'h0123_4567_89AB_CDEF;
      @(posedge clk);
      #1;
      chk("rst_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      @(negedge clk);
      rst = 0;
      xact(0, 0, 0, 64'h103, 0, 64'hFFFF_FFFF_FFFF_FF89, 0, 3, 0, 0);
      xact(0, 0, 1, 64'h103, 0, 64'h0000_0000_0000_0089, 0, 3, 0, 0);
      xact(0, 1, 0, 64'h106, 0, 64'h0000_0000_0000_0123, 0, 3, 0, 0);
      xact(0, 2, 0, 64'h100, 0, 64'hFFFF_FFFF_89AB_CDEF, 0, 3, 0, 0);
      xact(0, 2, 0, 64'h104, 0, 64'h0000_0000_0123_4567, 0, 3, 0, 0);
      xact(1, 1, 0, 64'h102, 64'hDEAD_BEEF, 0, 0, 4, 1, 3);
      chk("sh_mem_addr", last_wa, 64'h100);
      chk("sh_mem_wdata", last_wd, 64'h0123_4567_BEEF_CDEF);
      xact(0, 3, 0, 64'h100, 0, 64'h0123_4567_BEEF_CDEF, 0, 3, 0, 0);
      xact(1, 3, 0, 64'h108, 64'hAAAA_5555_AAAA_5555, 0, 0, 2, 1, 1);
      chk("sd_mem_addr", last_wa, 64'h108);
      chk("sd_mem", mem[33], 64'hAAAA_5555_AAAA_5555);
      xact(0, 3, 1, 64'h108, 0, 64'hAAAA_5555_AAAA_5555, 0, 3, 0, 0);
      xact(0, 2, 0, 64'h102, 0, 64'h0, 1, 1, 0, 0);
      xact(1, 3, 0, 64'h104, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1, 0, 0);
      chk("mis_mem_100", mem[32], 64'h0123_4567_BEEF_CDEF);
      chk("mis_mem_108", mem[33], 64'hAAAA_5555_AAAA_5555);
      begin
         int w0;
         w0 = wr_cnt;
         issue(1, 0, 0, 64'h101, 64'h77);
         chk("sb_in_rd_busy", {63'd0, req_ready}, 64'd0);
         @(negedge clk);
         rst = 1;
         #1;
         chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
         chk("mid_rst_mem_wr", {63'd0, mem_wr}, 64'd0);
         chk("mid_rst_mem_addr", mem_addr, 64'd0);
         chk("mid_rst_mem_wdata", mem_wdata, 64'd0);
         chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
         repeat (2) @(negedge clk);
         rst = 0;
         repeat (3) @(negedge clk);
         chk("mid_rst_no_write", 64'(wr_cnt - w0), 64'd0);
         chk("mid_rst_mem", mem[32], 64'h0123_4567_BEEF_CDEF);
         chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
      end
      xact(0, 0, 0, 64'h101, 0, 64'hFFFF_FFFF_FFFF_FFCD, 0, 3, 0, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
